// File: rtl/d8m_sensor_emulator.sv
// d8m_sensor_emulator: parallel camera-sensor emulator producing D/FVAL/LVAL frames with test patterns.
// Latency: all outputs registered; pixel data is aligned with LVAL (no skew), FVAL rises one cycle after enable.
// Backpressure: none, the sensor bus is free-running. Optional macro D8M_EMU_LFSR_EN turns pattern 11 into an LFSR.
module d8m_sensor_emulator #(
  parameter int DATA_W   = 12,
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 20000,
  parameter int FV_TO_LV = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  output logic [DATA_W-1:0] cam_D,
  output logic              cam_FVAL,
  output logic              cam_LVAL,
  output logic              frame_done,
  output logic [15:0]       frame_count
);

  localparam int MAX_AB  = (FV_TO_LV > H_BLANK) ? FV_TO_LV : H_BLANK;
  localparam int MAX_BLK = (MAX_AB > V_BLANK) ? MAX_AB : V_BLANK;
  localparam int CNT_W   = $clog2(MAX_BLK + 1);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(FV_TO_LV - 1);
  localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] VB_LAST  = CNT_W'(V_BLANK - 1);
  localparam logic [15:0]      X_LAST   = 16'(H_ACTIVE - 1);
  localparam logic [15:0]      Y_LAST   = 16'(V_ACTIVE - 1);

  // Width of one colour bar; tiny lines still get one pixel per bar.
  localparam int          BAR_LEN  = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [15:0] BAR_LAST = 16'(BAR_LEN - 1);
  localparam longint      FS       = (longint'(1) << DATA_W) - 1;
  localparam logic [DATA_W-1:0] ONES = '1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [15:0]       r_x;
  logic [15:0]       r_y;
  logic [2:0]        r_bar;
  logic [15:0]       r_bar_cnt;
  logic [1:0]        r_sel;

  logic              w_in_act;
  logic              w_last_px;
  logic              w_bar_step;
  logic              w_pre_entry;
  logic [15:0]       w_nx_x;
  logic [15:0]       w_nx_y;
  logic [2:0]        w_nx_bar;
  logic [15:0]       w_nx_bar_cnt;
  logic [DATA_W-1:0] w_pix;

  // Bar level k*(2^DATA_W-1)/7 from constant terms only, so no divider is built.
  function automatic logic [DATA_W-1:0] bar_value(input logic [2:0] b);
    case (b)
      3'd0:    bar_value = '0;
      3'd1:    bar_value = DATA_W'((FS * 1) / 7);
      3'd2:    bar_value = DATA_W'((FS * 2) / 7);
      3'd3:    bar_value = DATA_W'((FS * 3) / 7);
      3'd4:    bar_value = DATA_W'((FS * 4) / 7);
      3'd5:    bar_value = DATA_W'((FS * 5) / 7);
      3'd6:    bar_value = DATA_W'((FS * 6) / 7);
      default: bar_value = ONES;
    endcase
  endfunction

  assign w_in_act    = (r_state == S_ACTIVE);
  assign w_last_px   = (r_x == X_LAST);
  assign w_bar_step  = (r_bar_cnt == BAR_LAST) && (r_bar != 3'd7);
  assign w_pre_entry = enable && ((r_state == S_IDLE) ||
                                  ((r_state == S_VBLANK) && (r_cnt == VB_LAST)));
  // Only used when the next cycle is a pixel: HBLANK exit starts the next line.
  assign w_nx_y      = (r_state == S_HBLANK) ? r_y + 16'd1 : r_y;

  // Coordinates of the pixel shown next cycle; zero whenever a new line starts.
  always_comb begin
    w_nx_x       = 16'd0;
    w_nx_bar     = 3'd0;
    w_nx_bar_cnt = 16'd0;
    if (w_in_act && !w_last_px) begin
      w_nx_x = r_x + 16'd1;
      if (w_bar_step) begin
        w_nx_bar     = r_bar + 3'd1;
        w_nx_bar_cnt = 16'd0;
      end else begin
        w_nx_bar     = r_bar;
        w_nx_bar_cnt = r_bar_cnt + 16'd1;
      end
    end
  end

`ifdef D8M_EMU_LFSR_EN
  logic [11:0] r_lfsr;
  logic [11:0] w_nx_lfsr;

  // r_lfsr is the value of the pixel on the bus; it steps once per active pixel.
  assign w_nx_lfsr = w_in_act ? {r_lfsr[10:0], r_lfsr[11] ^ r_lfsr[5] ^ r_lfsr[3] ^ r_lfsr[0]}
                              : r_lfsr;

  // Reseed at every frame start so all frames carry the same sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= 12'hACE;
    end else if (w_pre_entry) begin
      r_lfsr <= 12'hACE;
    end else begin
      r_lfsr <= w_nx_lfsr;
    end
  end
`endif

  // Pattern value for the next pixel, selected by the per-frame latched pattern.
  always_comb begin
    w_pix = '0;
    case (r_sel)
      2'b00:   w_pix = DATA_W'(w_nx_x);
      2'b01:   w_pix = DATA_W'(w_nx_y);
      2'b10:   w_pix = bar_value(w_nx_bar);
`ifdef D8M_EMU_LFSR_EN
      default: w_pix = DATA_W'(w_nx_lfsr);
`else
      default: w_pix = (w_nx_x[0] ^ w_nx_y[0]) ? ONES : '0;
`endif
    endcase
  end

  // Frame FSM; outputs are set for the state being entered so they stay registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_x         <= 16'd0;
      r_y         <= 16'd0;
      r_bar       <= 3'd0;
      r_bar_cnt   <= 16'd0;
      r_sel       <= 2'b00;
      cam_D       <= '0;
      cam_FVAL    <= 1'b0;
      cam_LVAL    <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state  <= S_PRE;
            r_cnt    <= '0;
            r_y      <= 16'd0;
            r_sel    <= pattern_sel;
            cam_FVAL <= 1'b1;
          end
        end
        S_PRE: begin
          if (r_cnt == PRE_LAST) begin
            r_state   <= S_ACTIVE;
            r_cnt     <= '0;
            r_x       <= w_nx_x;
            r_bar     <= w_nx_bar;
            r_bar_cnt <= w_nx_bar_cnt;
            cam_LVAL  <= 1'b1;
            cam_D     <= w_pix;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ACTIVE: begin
          r_x       <= w_nx_x;
          r_bar     <= w_nx_bar;
          r_bar_cnt <= w_nx_bar_cnt;
          if (w_last_px) begin
            r_cnt    <= '0;
            cam_LVAL <= 1'b0;
            cam_D    <= '0;
            if (r_y == Y_LAST) begin
              r_state     <= S_VBLANK;
              cam_FVAL    <= 1'b0;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end else begin
              r_state <= S_HBLANK;
            end
          end else begin
            cam_D <= w_pix;
          end
        end
        S_HBLANK: begin
          if (r_cnt == HB_LAST) begin
            r_state  <= S_ACTIVE;
            r_cnt    <= '0;
            r_y      <= w_nx_y;
            cam_LVAL <= 1'b1;
            cam_D    <= w_pix;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_VBLANK: begin
          if (r_cnt == VB_LAST) begin
            r_cnt <= '0;
            if (enable) begin
              r_state  <= S_PRE;
              r_y      <= 16'd0;
              r_sel    <= pattern_sel;
              cam_FVAL <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
